// File: rtl/axi_byte_pkg.sv
// Shared types and constants for the AXI-to-byte-port responder.
package axi_byte_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BYTE,
    ST_WR_RESP,
    ST_RD_BYTE,
    ST_RD_RESP
  } state_t;

  typedef logic [2:0] lane_t;

endpackage

// File: rtl/axi_byte_lane_pick.sv
// Lowest-set-bit encoder: selects the next byte lane still pending in a write strobe.
module axi_byte_lane_pick
  import axi_byte_pkg::*;
(
  input  logic [7:0] strb,
  output lane_t      lane,
  output logic       none
);

  always_comb begin
    lane = '0;
    none = 1'b1;
    // scan high to low so the lowest set bit is the last one written
    for (int unsigned i = 0; i < 8; i++) begin
      if (strb[7 - i]) begin
        lane = lane_t'(7 - i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_byte_target.sv
// Single-beat AXI responder that serialises reads/writes into req/ack byte accesses
// on a local 8-bit port inside a decoded address window.
module axi_byte_target
  import axi_byte_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WIN_BITS  = 12,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [31:0]         s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [63:0]         s_axi_wdata,
  input  logic [7:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [31:0]         s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [63:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [WIN_BITS-1:0] byte_addr,
  output logic                byte_write,
  output logic [7:0]          byte_wdata,
  output logic                byte_req,
  input  logic                byte_ack,
  input  logic [7:0]          byte_rdata
);

  state_t      state, state_nxt;
  logic        aw_held, w_held, ar_held, last_wr;
  logic [31:0] awaddr_q, araddr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strb_q;
  logic [31:0] tmo_cnt;
  lane_t       lane;
  logic        lane_none;
  logic        aw_in_win, ar_in_win, last_lane, tmo_last;
  logic        pick_wr, pick_rd, start_req, ack_ok, expire, b_done, r_done;

  axi_byte_lane_pick u_lane_pick (
    .strb (strb_q),
    .lane (lane),
    .none (lane_none)
  );

  assign aw_in_win = (awaddr_q >> WIN_BITS) == (BASE_ADDR >> WIN_BITS);
  assign ar_in_win = (araddr_q >> WIN_BITS) == (BASE_ADDR >> WIN_BITS);
  assign last_lane = (strb_q & ~(8'd1 << lane)) == '0;
  assign tmo_last  = (TIMEOUT != 0) && (tmo_cnt == 32'd1);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick_wr   = 1'b0;
    pick_rd   = 1'b0;
    start_req = 1'b0;
    ack_ok    = 1'b0;
    expire    = 1'b0;
    b_done    = 1'b0;
    r_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aw_held && w_held && (!ar_held || !last_wr)) pick_wr = 1'b1;
        else if (ar_held)                                pick_rd = 1'b1;
        if (pick_wr)      state_nxt = aw_in_win ? ST_WR_BYTE : ST_WR_RESP;
        else if (pick_rd) state_nxt = ar_in_win ? ST_RD_BYTE : ST_RD_RESP;
      end
      ST_WR_BYTE: begin
        // req is deasserted for one cycle between lanes, so each lane starts from req low
        if (byte_req) begin
          if (byte_ack) begin
            ack_ok = 1'b1;
            if (last_lane) state_nxt = ST_WR_RESP;
          end else if (tmo_last) begin
            expire    = 1'b1;
            state_nxt = ST_WR_RESP;
          end
        end else if (lane_none) begin
          state_nxt = ST_WR_RESP;
        end else begin
          start_req = 1'b1;
        end
      end
      ST_RD_BYTE: begin
        if (byte_req) begin
          if (byte_ack) begin
            ack_ok    = 1'b1;
            state_nxt = ST_RD_RESP;
          end else if (tmo_last) begin
            expire    = 1'b1;
            state_nxt = ST_RD_RESP;
          end
        end else begin
          start_req = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          b_done    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (s_axi_rvalid && s_axi_rready) begin
          r_done    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      ar_held       <= 1'b0;
      last_wr       <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      tmo_cnt       <= '0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_arready <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      byte_req      <= 1'b0;
      byte_write    <= 1'b0;
      byte_addr     <= '0;
      byte_wdata    <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held       <= 1'b1;
        s_axi_awready <= 1'b0;
        awaddr_q      <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held       <= 1'b1;
        s_axi_wready <= 1'b0;
        wdata_q      <= s_axi_wdata;
        strb_q       <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        ar_held       <= 1'b1;
        s_axi_arready <= 1'b0;
        araddr_q      <= s_axi_araddr;
      end

      if (pick_wr) begin
        last_wr     <= 1'b1;
        s_axi_bresp <= aw_in_win ? RESP_OKAY : RESP_DECERR;
      end
      if (pick_rd) begin
        last_wr     <= 1'b0;
        s_axi_rresp <= ar_in_win ? RESP_OKAY : RESP_DECERR;
        s_axi_rdata <= '0;
      end

      if (start_req) begin
        byte_req   <= 1'b1;
        tmo_cnt    <= TIMEOUT;
        byte_write <= (state == ST_WR_BYTE);
        if (state == ST_WR_BYTE) begin
          byte_addr  <= {awaddr_q[WIN_BITS-1:3], lane};
          byte_wdata <= wdata_q[8*lane +: 8];
        end else begin
          byte_addr  <= araddr_q[WIN_BITS-1:0];
          byte_wdata <= '0;
        end
      end

      if (ack_ok) begin
        byte_req <= 1'b0;
        if (byte_write) strb_q[lane] <= 1'b0;
        else            s_axi_rdata  <= {8{byte_rdata}};
      end else if (expire) begin
        byte_req <= 1'b0;
        strb_q   <= '0;
        if (byte_write) begin
          s_axi_bresp <= RESP_SLVERR;
        end else begin
          s_axi_rresp <= RESP_SLVERR;
          s_axi_rdata <= '0;
        end
      end else if (byte_req && (TIMEOUT != 0)) begin
        tmo_cnt <= tmo_cnt - 32'd1;
      end

      if (b_done) begin
        s_axi_bvalid  <= 1'b0;
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end else if (state == ST_WR_RESP) begin
        s_axi_bvalid <= 1'b1;
      end

      if (r_done) begin
        s_axi_rvalid  <= 1'b0;
        ar_held       <= 1'b0;
        s_axi_arready <= 1'b1;
      end else if (state == ST_RD_RESP) begin
        s_axi_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_byte_target.sv
// Self-checking bench for axi_byte_target: scenario tasks plus a local-port responder
// that pops expected byte accesses from a scoreboard queue as the DUT performs them.
module tb_axi_byte_target;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [11:0] byte_addr;
  logic        byte_write;
  logic [7:0]  byte_wdata;
  logic        byte_req;
  logic        byte_ack;
  logic [7:0]  byte_rdata;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t       exp_acc[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         req_hi_cnt = 0;
  bit         ack_en = 1'b1;
  int         ack_delay = 0;
  logic [7:0] rd_byte = 8'h00;

  always #5 aclk = ~aclk;

  axi_byte_target #(
    .BASE_ADDR (BASE),
    .WIN_BITS  (12),
    .TIMEOUT   (4)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .byte_addr     (byte_addr),
    .byte_write    (byte_write),
    .byte_wdata    (byte_wdata),
    .byte_req      (byte_req),
    .byte_ack      (byte_ack),
    .byte_rdata    (byte_rdata)
  );

  // Local peripheral model: acks ack_delay cycles after req and checks each access.
  initial begin
    int         age;
    acc_t       e;
    logic [7:0] d;
    age        = 0;
    byte_ack   = 1'b0;
    byte_rdata = 8'h00;
    forever begin
      @(posedge aclk); #1;
      byte_ack = 1'b0;
      if (byte_req === 1'b1) begin
        age++;
        req_hi_cnt++;
      end else begin
        age = 0;
      end
      if (byte_req === 1'b1 && ack_en && age == ack_delay + 1) begin
        byte_ack   = 1'b1;
        byte_rdata = rd_byte;
        d = byte_write ? byte_wdata : 8'h00;
        n_checks++;
        if (exp_acc.size() == 0) begin
          n_fail++;
          $display("FAIL local_access: got unexpected wr=%0b addr=%h data=%h, expected no access",
                   byte_write, byte_addr, d);
        end else begin
          e = exp_acc.pop_front();
          if (byte_write !== e.wr || byte_addr !== e.addr || d !== e.data) begin
            n_fail++;
            $display("FAIL local_access: got wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                     byte_write, byte_addr, d, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_acc(input logic wr, input logic [11:0] a, input logic [7:0] d);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = d;
    exp_acc.push_back(e);
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit hs = 1'b0;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_awready;
      @(posedge aclk); #1;
    end
    s_axi_awvalid = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL aw_handshake: got no awready, expected within 200 cycles"); end
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit hs = 1'b0;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_wready;
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL w_handshake: got no wready, expected within 200 cycles"); end
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit hs = 1'b0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      hs = s_axi_arready;
      @(posedge aclk); #1;
    end
    s_axi_arvalid = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL ar_handshake: got no arready, expected within 200 cycles"); end
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp, output bit stable);
    int n = 0;
    s_axi_bready = 1'b0;
    while (s_axi_bvalid !== 1'b1 && n < 200) begin @(posedge aclk); #1; n++; end
    n_checks++;
    if (s_axi_bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b_timeout: got bvalid=%b, expected 1 within 200 cycles", s_axi_bvalid);
      resp = 2'bxx; stable = 1'b0;
      return;
    end
    resp = s_axi_bresp; stable = 1'b1;
    repeat (hold) begin
      @(posedge aclk); #1;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== resp) stable = 1'b0;
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic wait_r(input int hold, output logic [1:0] resp, output logic [63:0] data,
                        output bit stable);
    int n = 0;
    s_axi_rready = 1'b0;
    while (s_axi_rvalid !== 1'b1 && n < 200) begin @(posedge aclk); #1; n++; end
    n_checks++;
    if (s_axi_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL r_timeout: got rvalid=%b, expected 1 within 200 cycles", s_axi_rvalid);
      resp = 2'bxx; data = 'x; stable = 1'b0;
      return;
    end
    resp = s_axi_rresp; data = s_axi_rdata; stable = 1'b1;
    repeat (hold) begin
      @(posedge aclk); #1;
      if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== resp || s_axi_rdata !== data) stable = 1'b0;
    end
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_readies: got %b, expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    n_checks++;
    if ({s_axi_bvalid, s_axi_rvalid, byte_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valids: got %b, expected 000", {s_axi_bvalid, s_axi_rvalid, byte_req});
    end
    n_checks++;
    if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h, expected 00 00 0",
               s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_write_two_lanes();
    logic [1:0] resp; bit st;
    ack_delay = 2;
    push_acc(1'b1, 12'h012, 8'hBB);
    push_acc(1'b1, 12'h015, 8'hAA);
    fork
      send_aw(BASE + 32'h10);
      send_w(64'h0000_AA00_00BB_0000, 8'h24);
    join
    wait_b(0, resp, st);
    n_checks++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL wr2_bresp: got %b, expected 00", resp); end
    n_checks++;
    if (exp_acc.size() != 0) begin n_fail++; $display("FAIL wr2_count: got %0d pending, expected 0", exp_acc.size()); end
  endtask

  task automatic test_read();
    logic [1:0] resp; logic [63:0] data; bit st;
    ack_delay = 1;
    rd_byte = 8'h5C;
    push_acc(1'b0, 12'h023, 8'h00);
    send_ar(BASE + 32'h23);
    wait_r(0, resp, data, st);
    n_checks++;
    if (resp !== 2'b00 || data !== 64'h5C5C_5C5C_5C5C_5C5C) begin
      n_fail++; $display("FAIL rd_basic: got resp=%b data=%h, expected 00 5c5c5c5c5c5c5c5c", resp, data);
    end
    rd_byte = 8'hA5;
    push_acc(1'b0, 12'hFFF, 8'h00);
    send_ar(BASE + 32'hFFF);
    wait_r(0, resp, data, st);
    n_checks++;
    if (resp !== 2'b00 || data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_fail++; $display("FAIL rd_top: got resp=%b data=%h, expected 00 a5a5a5a5a5a5a5a5", resp, data);
    end
  endtask

  task automatic test_decode_error();
    logic [1:0] resp; logic [63:0] data; bit st;
    req_hi_cnt = 0;
    fork
      send_aw(32'h1000_0010);
      send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    join
    wait_b(0, resp, st);
    n_checks++;
    if (resp !== 2'b11) begin n_fail++; $display("FAIL dec_bresp: got %b, expected 11", resp); end
    send_ar(BASE + 32'h1000);
    wait_r(0, resp, data, st);
    n_checks++;
    if (resp !== 2'b11 || data !== 64'h0) begin
      n_fail++; $display("FAIL dec_rresp: got resp=%b data=%h, expected 11 0", resp, data);
    end
    n_checks++;
    if (req_hi_cnt != 0) begin n_fail++; $display("FAIL dec_noreq: got %0d req cycles, expected 0", req_hi_cnt); end
  endtask

  task automatic test_timeout();
    logic [1:0] resp; logic [63:0] data; bit st;
    ack_en = 1'b0;
    req_hi_cnt = 0;
    send_ar(BASE + 32'h40);
    wait_r(0, resp, data, st);
    n_checks++;
    if (req_hi_cnt != 4) begin n_fail++; $display("FAIL tmo_rd_len: got %0d req cycles, expected 4", req_hi_cnt); end
    n_checks++;
    if (resp !== 2'b10 || data !== 64'h0) begin
      n_fail++; $display("FAIL tmo_rd_resp: got resp=%b data=%h, expected 10 0", resp, data);
    end
    req_hi_cnt = 0;
    fork
      send_aw(BASE + 32'h48);
      send_w(64'h0000_0000_0000_3344, 8'h03);
    join
    wait_b(0, resp, st);
    n_checks++;
    if (req_hi_cnt != 4 || resp !== 2'b10) begin
      n_fail++; $display("FAIL tmo_wr: got %0d req cycles resp=%b, expected 4 10", req_hi_cnt, resp);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_min_latency();
    logic [1:0] resp; bit st;
    int cyc = 0;
    ack_delay = 0;
    push_acc(1'b1, 12'h008, 8'hEE);
    fork
      send_aw(BASE + 32'h8);
      send_w(64'h0000_0000_0000_00EE, 8'h01);
    join
    while (s_axi_bvalid !== 1'b1 && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    n_checks++;
    if (cyc != 4) begin n_fail++; $display("FAIL min_latency: got bvalid at edge %0d, expected 4", cyc); end
    wait_b(0, resp, st);
    n_checks++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL min_lat_bresp: got %b, expected 00", resp); end
  endtask

  task automatic test_zero_strb();
    logic [1:0] resp; bit st;
    req_hi_cnt = 0;
    fork
      send_aw(BASE + 32'h50);
      send_w(64'h1234_5678_9ABC_DEF0, 8'h00);
    join
    wait_b(0, resp, st);
    n_checks++;
    if (resp !== 2'b00 || req_hi_cnt != 0) begin
      n_fail++; $display("FAIL zero_strb: got resp=%b req cycles=%0d, expected 00 0", resp, req_hi_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [1:0] resp; bit st;
    int n = 0;
    ack_en = 1'b0;
    fork
      send_aw(BASE + 32'h30);
      send_w(64'h0000_0000_0000_0099, 8'h01);
    join
    while (byte_req !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
    n_checks++;
    if (byte_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got byte_req=%b, expected 1", byte_req); end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    n_checks++;
    if (byte_req !== 1'b0 || {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111 || s_axi_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got req=%b readies=%b bvalid=%b, expected 0 111 0",
               byte_req, {s_axi_awready, s_axi_wready, s_axi_arready}, s_axi_bvalid);
    end
    aresetn = 1'b1;
    ack_en = 1'b1;
    ack_delay = 1;
    push_acc(1'b1, 12'h03F, 8'h77);
    fork
      send_aw(BASE + 32'h38);
      send_w(64'h7700_0000_0000_0000, 8'h80);
    join
    wait_b(0, resp, st);
    n_checks++;
    if (resp !== 2'b00 || exp_acc.size() != 0) begin
      n_fail++; $display("FAIL rst_fresh_wr: got resp=%b pending=%0d, expected 00 0", resp, exp_acc.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [63:0] data; bit st;
    // fresh reset so the arbiter starts from write-first
    pulse_reset();
    ack_delay = 1;
    rd_byte = 8'h11;
    push_acc(1'b1, 12'h101, 8'h21);
    push_acc(1'b0, 12'h200, 8'h00);
    fork
      send_aw(BASE + 32'h100);
      send_w(64'h0000_0000_0000_2100, 8'h02);
      send_ar(BASE + 32'h200);
    join
    wait_b(10, resp, st);
    n_checks++;
    if (resp !== 2'b00 || !st) begin n_fail++; $display("FAIL b2b_b1: got resp=%b stable=%0b, expected 00 1", resp, st); end
    push_acc(1'b1, 12'h10E, 8'h46);
    fork
      send_aw(BASE + 32'h108);
      send_w(64'h0046_0000_0000_0000, 8'h40);
    join
    wait_r(10, resp, data, st);
    n_checks++;
    if (resp !== 2'b00 || data !== 64'h1111_1111_1111_1111 || !st) begin
      n_fail++; $display("FAIL b2b_r1: got resp=%b data=%h stable=%0b, expected 00 1111111111111111 1", resp, data, st);
    end
    rd_byte = 8'h22;
    push_acc(1'b0, 12'h2F8, 8'h00);
    send_ar(BASE + 32'h2F8);
    wait_b(10, resp, st);
    n_checks++;
    if (resp !== 2'b00 || !st) begin n_fail++; $display("FAIL b2b_b2: got resp=%b stable=%0b, expected 00 1", resp, st); end
    wait_r(10, resp, data, st);
    n_checks++;
    if (resp !== 2'b00 || data !== 64'h2222_2222_2222_2222 || !st) begin
      n_fail++; $display("FAIL b2b_r2: got resp=%b data=%h stable=%0b, expected 00 2222222222222222 1", resp, data, st);
    end
    n_checks++;
    if (exp_acc.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d, expected 0", exp_acc.size()); end
  endtask

  initial begin
    test_reset();
    test_write_two_lanes();
    test_read();
    test_decode_error();
    test_timeout();
    test_min_latency();
    test_zero_strb();
    test_reset_mid_access();
    test_back_to_back();
    repeat (5) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
